// File: rtl/pp_mult_ctrl.sv
// Sequencer for one shift-add multiplier lane: walks LOAD, then ADD/SHIFT per
// multiplier bit, then DONE, and drives the partial-product datapath selects.
module pp_mult_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          mult_lsb,
  output logic                          ld_operands,
  output logic                          clr_pp,
  output logic                          add_en,
  output logic                          shift_en,
  output logic                          en_PPReg,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(DATA_WIDTH)-1:0] iter_cnt
);

  localparam int unsigned   CW        = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    ld_operands = 1'b0;
    clr_pp      = 1'b0;
    add_en      = 1'b0;
    shift_en    = 1'b0;
    en_PPReg    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        iter_d = '0;
        if (start) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        ld_operands = 1'b1;
        clr_pp      = 1'b1;
        en_PPReg    = 1'b1;
        busy        = 1'b1;
        iter_d      = '0;
        state_d     = S_ADD;
      end

      S_ADD: begin
        busy     = 1'b1;
        add_en   = mult_lsb;
        en_PPReg = mult_lsb;
        state_d  = S_SHIFT;
      end

      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        en_PPReg = 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter_q + CW'(1);
          state_d = S_ADD;
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        iter_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        iter_d  = '0;
      end
    endcase

    // abort only redirects the next state; this cycle's outputs stay as decoded above
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      iter_d  = '0;
    end
  end

  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_pp_mult_ctrl.sv
// Vector-table bench for pp_mult_ctrl (DATA_WIDTH=8) with a queue-based
// scoreboard plus hand-written reset sequences.
module tb_pp_mult_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, mult_lsb;
  logic       ld_operands, clr_pp, add_en, shift_en, en_PPReg, busy, done;
  logic [2:0] iter_cnt;

  pp_mult_ctrl #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .mult_lsb    (mult_lsb),
    .ld_operands (ld_operands),
    .clr_pp      (clr_pp),
    .add_en      (add_en),
    .shift_en    (shift_en),
    .en_PPReg    (en_PPReg),
    .busy        (busy),
    .done        (done),
    .iter_cnt    (iter_cnt)
  );

  always #5 clk = ~clk;

  // output bit order: {ld_operands, clr_pp, add_en, shift_en, en_PPReg, busy, done}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_LOAD  = 7'b1100110;
  localparam logic [6:0] O_ADD1  = 7'b0010110;
  localparam logic [6:0] O_ADD0  = 7'b0000010;
  localparam logic [6:0] O_SHIFT = 7'b0001110;
  localparam logic [6:0] O_DONE  = 7'b0000011;

  typedef struct {
    logic       start;
    logic       abort;
    logic       lsb;
    logic [6:0] exp;
    logic [2:0] iter;
    int         id;
  } vec_t;

  typedef struct {
    logic [6:0] exp;
    logic [2:0] iter;
    int         id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  exp_t cur;
  int   next_id = 0;
  int   n_vec   = 0;
  int   n_bad   = 0;

  task automatic check(input string nm, input logic [6:0] exp, input logic [2:0] ei);
    logic [6:0] got;
    got = {ld_operands, clr_pp, add_en, shift_en, en_PPReg, busy, done};
    n_vec++;
    if (got !== exp || iter_cnt !== ei) begin
      n_bad++;
      $display("FAIL %s: got outputs=%b iter_cnt=%0d, expected outputs=%b iter_cnt=%0d",
               nm, got, iter_cnt, exp, ei);
    end
  endtask

  task automatic check_excl(input int id);
    n_vec++;
    if ($countones({clr_pp, add_en, shift_en}) > 1) begin
      n_bad++;
      $display("FAIL excl_vec%0d: got selects clr/add/shift=%b, expected at most one high",
               id, {clr_pp, add_en, shift_en});
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      check($sformatf("vec%0d", cur.id), cur.exp, cur.iter);
      check_excl(cur.id);
    end
  end

  task automatic add(input logic s, input logic a, input logic l,
                     input logic [6:0] e, input logic [2:0] it);
    vec_t v;
    v.start = s;
    v.abort = a;
    v.lsb   = l;
    v.exp   = e;
    v.iter  = it;
    v.id    = next_id;
    next_id++;
    tbl.push_back(v);
  endtask

  task automatic gen_idle(input int n, input logic s, input logic a);
    for (int i = 0; i < n; i++) add(s, a, 1'b1, O_IDLE, 3'd0);
  endtask

  // c=0 IDLE with start, c=1 LOAD, even c ADD / odd c SHIFT of bit (c-2)/2, c=18 DONE
  task automatic gen_product(input logic [7:0] pat, input bit hold, input logic [7:0] smask,
                             input int abort_cyc, input bit abort_at_start, input int stop_cyc);
    for (int c = 0; c <= 18; c++) begin
      int         k;
      logic       s, a, l;
      logic [6:0] e;
      logic [2:0] it;
      if (c == stop_cyc) break;
      k  = (c - 2) / 2;
      a  = (c == abort_cyc) || (c == 0 && abort_at_start);
      s  = hold;
      l  = 1'b0;
      it = 3'd0;
      if (c == 0) begin
        s = 1'b1;
        e = O_IDLE;
      end else if (c == 1) begin
        l = 1'b1;
        e = O_LOAD;
      end else if (c == 18) begin
        e  = O_DONE;
        it = 3'd7;
      end else if (c % 2 == 0) begin
        s  = hold | smask[k];
        l  = pat[k];
        e  = pat[k] ? O_ADD1 : O_ADD0;
        it = 3'(k);
      end else begin
        l  = ~pat[k];
        e  = O_SHIFT;
        it = 3'(k);
      end
      add(s, a, l, e, it);
      if (c == abort_cyc) break;
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    start    = v.start;
    abort    = v.abort;
    mult_lsb = v.lsb;
    e.exp    = v.exp;
    e.iter   = v.iter;
    e.id     = v.id;
    sb_q.push_back(e);
  endtask

  task automatic apply_tbl();
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    mult_lsb = 1'b1;
    #1;
    check("rst_async", O_IDLE, 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_hold%0d", i), O_IDLE, 3'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b0;

    gen_idle(3, 1'b0, 1'b0);
    gen_idle(2, 1'b0, 1'b1);                          // abort in IDLE is inert
    gen_product(8'hA5, 0, 8'h00, -1, 0, -1);          // 0xA5 LSB-first
    gen_idle(2, 1'b0, 1'b0);
    gen_product(8'h3C, 0, 8'b0100_0100, -1, 0, -1);  // start during iterations 2 and 6
    gen_idle(2, 1'b0, 1'b0);
    gen_product(8'h5A, 0, 8'h00, 9, 0, -1);           // abort in SHIFT of iteration 3
    gen_idle(1, 1'b0, 1'b0);
    gen_product(8'hFF, 0, 8'h00, -1, 0, -1);
    gen_idle(1, 1'b0, 1'b0);
    gen_product(8'h0F, 0, 8'h00, 1, 1, -1);           // start+abort in IDLE, abort in LOAD
    gen_idle(1, 1'b0, 1'b0);
    gen_product(8'h81, 0, 8'h00, 2, 0, -1);           // abort in first ADD
    gen_idle(1, 1'b0, 1'b0);
    gen_product(8'h96, 1, 8'h00, -1, 0, -1);          // start held 40 cycles
    gen_product(8'h69, 1, 8'h00, -1, 0, -1);
    add(1'b1, 1'b0, 1'b0, O_IDLE, 3'd0);
    add(1'b1, 1'b0, 1'b1, O_LOAD, 3'd0);
    add(1'b0, 1'b1, 1'b1, O_ADD1, 3'd0);
    gen_idle(2, 1'b0, 1'b0);
    gen_product(8'hFF, 0, 8'h00, -1, 0, 10);          // stop just before ADD of iteration 4
    apply_tbl();

    add(1'b0, 1'b0, 1'b1, O_ADD1, 3'd4);
    drive(tbl[0]);
    tbl.delete();
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_add", O_IDLE, 3'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_mid_hold%0d", i), O_IDLE, 3'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    gen_idle(3, 1'b0, 1'b0);
    gen_product(8'hC3, 0, 8'h00, -1, 0, -1);
    gen_idle(2, 1'b0, 1'b0);
    apply_tbl();

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
